// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes, funct3 codes and FSM states.
package dmem_responder_pkg;

    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

    // Loads and stores share the size encoding in funct3[1:0].
    function automatic mem_size_t size_of(input logic [2:0] fun3);
        case (fun3[1:0])
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select plus sign/zero extension of a 32-bit memory word.
module load_align_ext
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  fun3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[8*off +: 8];
        lane_h = off[1] ? word[31:16] : word[15:0];
        case (fun3)
            LB:      result = {{24{lane_b[7]}}, lane_b};
            LH:      result = {{16{lane_h[15]}}, lane_h};
            LW:      result = word;
            LBU:     result = {24'd0, lane_b};
            LHU:     result = {16'd0, lane_h};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request, programmable wait states, byte-lane stores.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses instead of forcing alignment.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fun3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         LA_W     = ADDR_W + 2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [2:0]        lat_fun3;
    logic [LA_W-1:0]   lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       mem [2**ADDR_W];

    mem_size_t         size;
    logic              illegal;
    logic              misalign;
    logic              err;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wrep;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       load_word;
    logic [31:0]       load_data;

    // Upper address bits alias onto the same words, so they are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:LA_W];

    assign req_ready = (state == IDLE) && !reset;

    always_comb begin
        size     = size_of(lat_fun3);
        illegal  = lat_we ? !(lat_fun3 inside {SB, SH, SW})
                          : !(lat_fun3 inside {LB, LH, LW, LBU, LHU});
        idx      = lat_addr[LA_W-1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = ((size == HALF) && lat_addr[0]) ||
                   ((size == WORD) && (lat_addr[1:0] != 2'b00));
        off      = lat_addr[1:0];
`else
        misalign = 1'b0;
        case (size)
            BYTE:    off = lat_addr[1:0];
            HALF:    off = {lat_addr[1], 1'b0};
            default: off = 2'b00;
        endcase
`endif
        err = illegal || misalign;
        case (size)
            BYTE: begin
                be   = 4'b0001 << off;
                wrep = {4{lat_wdata[7:0]}};
            end
            HALF: begin
                be   = 4'b0011 << off;
                wrep = {2{lat_wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = lat_wdata;
            end
        endcase
    end

    assign load_word = mem[idx];

    load_align_ext u_align (
        .word   (load_word),
        .off    (off),
        .fun3   (lat_fun3),
        .result (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_fun3  <= 3'd0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_fun3  <= req_fun3;
                        lat_addr  <= req_addr[LA_W-1:0];
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (err || lat_we) ? 32'd0 : load_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory has no reset; a reset landing on the ACCESS edge must still block the write.
    always_ff @(posedge clk) begin
        if (!reset && (state == ACCESS) && lat_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (ADDR_W=10, WAIT_CYCLES=1).
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_fun3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] r;
    logic        e;
    int          l;
    logic        seen;
    logic [31:0] exp10;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_fun3  (req_fun3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            passCount++;
    endtask

    // One full transaction; latency counts the accept edge as edge 1.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        req_we    = we;
        req_fun3  = f3;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold_data", rsp_rdata, rdata);
            checkOutput("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_fun3  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'd0, req_ready}, 32'd1);
        checkOutput("valid_after_reset", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rdata_after_reset", rsp_rdata, 32'd0);
        checkOutput("err_after_reset", {31'd0, rsp_err}, 32'd0);

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, r, e, l);
        checkOutput("sw_rdata_zero", r, 32'd0);
        checkOutput("sw_err", {31'd0, e}, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 0, r, e, l);
        checkOutput("lw_10", r, 32'hDEADBEEF);
        checkOutput("lw_10_err", {31'd0, e}, 32'd0);
        checkOutput("latency", l, 32'd3);

        applyStimulus(1'b1, 3'b000, 32'h13, 32'h00000080, 0, r, e, l);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'd0, 0, r, e, l);
        checkOutput("lb_13", r, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'd0, 0, r, e, l);
        checkOutput("lbu_13", r, 32'h00000080);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 0, r, e, l);
        checkOutput("lw_10_after_sb", r, 32'h80ADBEEF);

        applyStimulus(1'b1, 3'b010, 32'h20, 32'h00000000, 0, r, e, l);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h00008001, 0, r, e, l);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'd0, 0, r, e, l);
        checkOutput("lh_22", r, 32'hFFFF8001);
        applyStimulus(1'b0, 3'b101, 32'h22, 32'd0, 0, r, e, l);
        checkOutput("lhu_22", r, 32'h00008001);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'd0, 0, r, e, l);
        checkOutput("lw_20_after_sh", r, 32'h80010000);

        applyStimulus(1'b1, 3'b010, 32'h30, 32'h11112222, 0, r, e, l);
        req_we    = 1'b1;
        req_fun3  = 3'b010;
        req_addr  = 32'h30;
        req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid;
        end
        checkOutput("no_rsp_after_wait_reset", {31'd0, seen}, 32'd0);
        checkOutput("ready_after_wait_reset", {31'd0, req_ready}, 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'd0, 0, r, e, l);
        checkOutput("lw_30_unchanged", r, 32'h11112222);

        applyStimulus(1'b0, 3'b011, 32'h10, 32'd0, 0, r, e, l);
        checkOutput("illegal_load_err", {31'd0, e}, 32'd1);
        checkOutput("illegal_load_rdata", r, 32'd0);
        applyStimulus(1'b1, 3'b011, 32'h30, 32'h0, 0, r, e, l);
        checkOutput("illegal_store_err", {31'd0, e}, 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'd0, 0, r, e, l);
        checkOutput("lw_30_after_illegal", r, 32'h11112222);

        applyStimulus(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, 0, r, e, l);
`ifdef DMEM_MISALIGN_CHECK_EN
        checkOutput("sw_11_err", {31'd0, e}, 32'd1);
        exp10 = 32'h80ADBEEF;
`else
        checkOutput("sw_11_err", {31'd0, e}, 32'd0);
        exp10 = 32'hCAFEF00D;
`endif
        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 0, r, e, l);
        checkOutput("lw_10_after_misalign", r, exp10);
        applyStimulus(1'b0, 3'b001, 32'h23, 32'd0, 0, r, e, l);
`ifdef DMEM_MISALIGN_CHECK_EN
        checkOutput("lh_23_err", {31'd0, e}, 32'd1);
        checkOutput("lh_23_rdata", r, 32'd0);
`else
        checkOutput("lh_23_err", {31'd0, e}, 32'd0);
        checkOutput("lh_23_rdata", r, 32'hFFFF8001);
`endif

        applyStimulus(1'b0, 3'b010, 32'h10, 32'd0, 5, r, e, l);
        checkOutput("hold_lw_10", r, exp10);
        checkOutput("valid_cleared", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rdata_cleared", rsp_rdata, 32'd0);

        applyStimulus(1'b1, 3'b010, 32'h1000, 32'h12345678, 0, r, e, l);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'd0, 0, r, e, l);
        checkOutput("wrap_lw_0", r, 32'h12345678);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
